// File: rtl/rca_64_bit_seq_ctrl.sv
// Sequential 64-bit ripple-carry adder: one SLICE_W-bit slice reused over 64/SLICE_W cycles.
// Optional subtract support is enabled by defining RCA_SEQ_SUB_EN.
module rca_64_bit_seq_ctrl #(
    parameter int SLICE_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    input  logic        sub,
    output logic        busy,
    output logic        done,
    output logic [63:0] sum,
    output logic        cout,
    output logic        overflow,
    output logic [1:0]  state_dbg
);

    localparam int N     = 64 / SLICE_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [63:0] SLICE_MASK = 64'({SLICE_W{1'b1}});

    if ((SLICE_W != 8) && (SLICE_W != 16) && (SLICE_W != 32) && (SLICE_W != 64)) begin : g_bad_slice_w
        $error("rca_64_bit_seq_ctrl: SLICE_W must be 8, 16, 32 or 64");
    end

    // Handshake: start is sampled on every rising edge; it is accepted only in
    // IDLE or DONE. busy is high exactly in RUN, done exactly in DONE (one cycle).
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [63:0]        a_q, a_d;
    logic [63:0]        b_q, b_d;
    logic [63:0]        sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [63:0]        b_cap;
    logic               cin_cap;
    logic [6:0]         sh;
    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;
    logic               last_slice;

`ifdef RCA_SEQ_SUB_EN
    // Subtraction is a + ~b + 1, so the carry-in is forced high.
    assign b_cap   = sub ? ~b : b;
    assign cin_cap = sub ? 1'b1 : cin;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_cap      = b;
    assign cin_cap    = cin;
`endif

    assign sh         = 7'(idx_q) * 7'(SLICE_W);
    assign slice_a    = SLICE_W'(a_q >> sh);
    assign slice_b    = SLICE_W'(b_q >> sh);
    assign last_slice = (idx_q == IDX_W'(N - 1));

    always_comb begin
        logic c;
        slice_sum = '0;
        c         = carry_q;
        for (int i = 0; i < SLICE_W; i++) begin
            slice_sum[i] = slice_a[i] ^ slice_b[i] ^ c;
            c            = (slice_a[i] & slice_b[i]) | (c & (slice_a[i] ^ slice_b[i]));
        end
        slice_cout = c;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b_cap;
                    carry_d = cin_cap;
                    idx_d   = '0;
                    state_d = RUN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d   = (sum_q & ~(SLICE_MASK << sh)) | (64'(slice_sum) << sh);
                carry_d = slice_cout;
                if (last_slice) begin
                    idx_d   = '0;
                    cout_d  = slice_cout;
                    // Signed overflow: operands agree in sign but the result does not.
                    ovf_d   = (a_q[63] == b_q[63]) && (sum_d[63] != a_q[63]);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_rca_64_bit_seq_ctrl.sv
// Self-checking bench for rca_64_bit_seq_ctrl: directed corner cases plus random operands
// compared against an arithmetic reference model.
module tb_rca_64_bit_seq_ctrl;

    localparam int SLICE_W = 16;
    localparam int N       = 64 / SLICE_W;
    localparam int BOUND   = 50;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
    logic        busy;
    logic        done;
    logic [63:0] sum;
    logic        cout;
    logic        overflow;
    logic [1:0]  state_dbg;

    int n_checks;
    int n_errors;
    int done_cnt;

    // Expected results packed as {overflow, cout, sum}.
    logic [65:0] exp_q[$];

    rca_64_bit_seq_ctrl #(.SLICE_W(SLICE_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [65:0] model(input logic [63:0] a_i, input logic [63:0] b_i,
                                          input logic cin_i, input logic sub_i);
        logic [63:0]        b_eff;
        logic               c_eff;
        logic [64:0]        uns;
        logic signed [65:0] sgn;
        logic               ovf;
        b_eff = b_i;
        c_eff = cin_i;
`ifdef RCA_SEQ_SUB_EN
        if (sub_i) begin
            b_eff = ~b_i;
            c_eff = 1'b1;
        end
`else
        if (sub_i) b_eff = b_i;
`endif
        uns = {1'b0, a_i} + {1'b0, b_eff} + 65'(c_eff);
        sgn = $signed({{2{a_i[63]}}, a_i}) + $signed({{2{b_eff[63]}}, b_eff}) + $signed({65'd0, c_eff});
        ovf = (sgn > $signed(66'h0_7FFF_FFFF_FFFF_FFFF)) || (sgn < -$signed(66'h0_8000_0000_0000_0000));
        return {ovf, uns[64], uns[63:0]};
    endfunction

    task automatic drive(input logic [63:0] a_i, input logic [63:0] b_i, input logic cin_i, input logic sub_i);
        a   = a_i;
        b   = b_i;
        cin = cin_i;
        sub = sub_i;
    endtask

    // Waits (from a negedge) until done is seen; lat counts rising edges since capture.
    task automatic wait_done(input int lat0, output int lat);
        lat = lat0;
        while (!done && lat < BOUND) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_result(input string tag);
        logic [65:0] e;
        e = exp_q.pop_front();
        check({tag, "_sum"}, {2'b00, sum}, {2'b00, e[63:0]});
        check({tag, "_cout"}, {65'd0, cout}, {65'd0, e[64]});
        check({tag, "_ovf"}, {65'd0, overflow}, {65'd0, e[65]});
    endtask

    task automatic do_op(input string tag, input logic [63:0] a_i, input logic [63:0] b_i,
                         input logic cin_i, input logic sub_i);
        int lat;
        exp_q.push_back(model(a_i, b_i, cin_i, sub_i));
        @(negedge clk);
        drive(a_i, b_i, cin_i, sub_i);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drive({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
        check({tag, "_busy"}, {65'd0, busy}, 66'd1);
        wait_done(0, lat);
        check({tag, "_lat"}, 66'(lat), 66'(N));
        check_result(tag);
        @(negedge clk);
        check({tag, "_done_off"}, {65'd0, done}, 66'd0);
    endtask

    initial begin
        int          lat;
        int          gap;
        int          cnt0;
        logic [63:0] ra;
        logic [63:0] rb;
        n_checks = 0;
        n_errors = 0;
        done_cnt = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        drive('0, '0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_busy", {65'd0, busy}, 66'd0);
        check("rst_done", {65'd0, done}, 66'd0);
        check("rst_sum", {2'b00, sum}, 66'd0);
        check("rst_cout", {65'd0, cout}, 66'd0);
        check("rst_ovf", {65'd0, overflow}, 66'd0);
        rst_n = 1'b1;

        // Unsigned wrap and signed overflow corners.
        do_op("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        do_op("sovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        do_op("neg_ovf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
        do_op("cin_chain", 64'h0000_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0);

        for (int i = 0; i < 20; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i % 5 == 1) rb = ~ra;
            do_op("rand", ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

`ifdef RCA_SEQ_SUB_EN
        do_op("sub", 64'd5, 64'd7, 1'b0, 1'b1);
`endif

        // start during RUN must be ignored.
        cnt0 = done_cnt;
        exp_q.push_back(model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0));
        @(negedge clk);
        drive(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0);
        start = 1'b1;
        @(negedge clk);
        drive(64'hFFFF_0000_FFFF_0000, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        wait_done(1, lat);
        check("ign_lat", 66'(lat), 66'(N));
        check_result("ign");
        repeat (8) @(negedge clk);
        #1;
        check("ign_one_done", 66'(done_cnt - cnt0), 66'd1);

        // Back-to-back: start held high, second capture happens in DONE.
        exp_q.push_back(model(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1'b0));
        exp_q.push_back(model(64'hDEAD_BEEF_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0));
        @(negedge clk);
        drive(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1'b0);
        start = 1'b1;
        @(negedge clk);
        drive(64'hDEAD_BEEF_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        wait_done(0, lat);
        check("b2b_lat1", 66'(lat), 66'(N));
        check_result("b2b1");
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", {65'd0, busy}, 66'd1);
        wait_done(1, gap);
        check("b2b_gap", 66'(gap), 66'(N + 1));
        check_result("b2b2");

        // Reset in the middle of RUN aborts without a done pulse.
        @(negedge clk);
        drive(64'h5555_5555_5555_5555, 64'h3333_3333_3333_3333, 1'b0, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < ((N > 2) ? 2 : N - 1); i++) @(negedge clk);
        cnt0 = done_cnt;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", {65'd0, busy}, 66'd0);
        check("abort_done", {65'd0, done}, 66'd0);
        check("abort_sum", {2'b00, sum}, 66'd0);
        check("abort_cout", {65'd0, cout}, 66'd0);
        check("abort_ovf", {65'd0, overflow}, 66'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check("abort_no_done", 66'(done_cnt - cnt0), 66'd0);
        do_op("post_rst", 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b1, 1'b0);

        check("queue_empty", 66'(exp_q.size()), 66'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
